wb_arbiter2: RTL and testbench

Two-master to one-slave Wishbone classic arbiter. It sits directly upstream of the SoC's Wishbone RAM and merges the CPU instruction-fetch bus (master 0) and data bus (master 1) onto the single RAM port. Grant is registered and held for the whole master cycle. A watchdog terminates stalled transfers with an error pulse.

---
 rtl/wb_arbiter2.sv | 146 ++++++++++++++
 tb/tb_wb_arbiter2.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter with a registered, cycle-held grant and a stall watchdog.
// Define ARB_ROUND_ROBIN_EN to break request ties by alternating masters instead of favouring m1.
module wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sel,
  input  logic        m0_we,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_cyc,
  output logic        s_stb,
  input  logic [31:0] s_rdata,
  input  logic        s_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic             last_grant, last_grant_next;  // 0 = m0, 1 = m1
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             err0_next, err1_next;
  logic             req0, req1;

  // A master requests with cyc&stb; a strobe completes when s_ack is seen with stb high.
  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      cnt        <= cnt_next;
      m0_err     <= err0_next;
      m1_err     <= err1_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    cnt_next        = '0;
    err0_next       = 1'b0;
    err1_next       = 1'b0;
    s_addr          = '0;
    s_wdata         = '0;
    s_sel           = '0;
    s_we            = 1'b0;
    s_cyc           = 1'b0;
    s_stb           = 1'b0;
    m0_ack          = 1'b0;
    m1_ack          = 1'b0;

    case (state)
      IDLE: begin
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (last_grant) begin
            state_next      = GNT0;
            last_grant_next = 1'b0;
          end else begin
            state_next      = GNT1;
            last_grant_next = 1'b1;
          end
`else
          state_next      = GNT1;
          last_grant_next = 1'b1;
`endif
        end else if (req1) begin
          state_next      = GNT1;
          last_grant_next = 1'b1;
        end else if (req0) begin
          state_next      = GNT0;
          last_grant_next = 1'b0;
        end
      end
      GNT0: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_sel   = m0_sel;
        s_we    = m0_we;
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        m0_ack  = s_ack;
        if (!m0_cyc) state_next = IDLE;
      end
      GNT1: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_sel   = m1_sel;
        s_we    = m1_we;
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        m1_ack  = s_ack;
        if (!m1_cyc) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Watchdog only counts stalled strobes; an ack in the limit cycle suppresses the error.
    if (state != IDLE && s_stb && !s_ack) begin
      if (cnt == CNT_LIMIT) begin
        err0_next = (state == GNT0);
        err1_next = (state == GNT1);
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (TIMEOUT_CYCLES=8); tie-break expectations follow ARB_ROUND_ROBIN_EN.
module tb_wb_arbiter2;
  localparam int TO = 8;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_sel;
  logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_sel;
  logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  wb_arbiter2 #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel), .s_we(s_we),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_rdata(s_rdata), .s_ack(s_ack)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_sel = sel;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_sel = sel;
  endtask

  task automatic idle_masters();
    drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    idle_masters();
    s_ack   = 1'b1;
    s_rdata = 32'hCAFE_0001;
    reset   = 1'b1;
    drive_m1(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    tick();
    tick();
    check("rst_s_cyc", 32'(s_cyc), 32'h0);
    check("rst_s_stb", 32'(s_stb), 32'h0);
    check("rst_s_we", 32'(s_we), 32'h0);
    check("rst_s_sel", 32'(s_sel), 32'h0);
    check("rst_s_addr", s_addr, 32'h0);
    check("rst_s_wdata", s_wdata, 32'h0);
    check("rst_m1_ack", 32'(m1_ack), 32'h0);
    check("rst_errs", 32'({m0_err, m1_err}), 32'h0);
    idle_masters();
    s_ack = 1'b0;
    reset = 1'b0;
    tick();

    // single m0 read; an ack seen while still IDLE must be dropped
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    s_ack = 1'b1;
    settle();
    check("rd_latency_stb", 32'(s_stb), 32'h0);
    check("idle_ack_drop", 32'(m0_ack), 32'h0);
    s_ack = 1'b0;
    tick();
    check("rd_s_stb", 32'(s_stb), 32'h1);
    check("rd_s_addr", s_addr, 32'h0000_0010);
    check("rd_wait_ack", 32'(m0_ack), 32'h0);
    tick();
    s_ack = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    settle();
    check("rd_m0_ack", 32'(m0_ack), 32'h1);
    check("rd_m1_ack", 32'(m1_ack), 32'h0);
    check("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("rd_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    tick();
    s_ack = 1'b0;
    idle_masters();
    settle();
    check("rd_release_cyc", 32'(s_cyc), 32'h0);
    check("rd_ack_gone", 32'(m0_ack), 32'h0);
    tick();

    // ties from a fresh reset: two rounds give four grants
    reset_pulse();
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A0); exp_q.push_back(A1);
`else
    exp_q.push_back(A1); exp_q.push_back(A0); exp_q.push_back(A1); exp_q.push_back(A0);
`endif
    for (int r = 0; r < 2; r++) begin
      drive_m0(1'b1, 1'b1, 1'b0, A0, 32'h0, 4'hF);
      drive_m1(1'b1, 1'b1, 1'b0, A1, 32'h0, 4'hF);
      settle();
      check("tie_idle_cyc", 32'(s_cyc), 32'h0);
      tick();
      exp_addr = exp_q.pop_front();
      check("tie_first_addr", s_addr, exp_addr);
      if (exp_addr == A0) drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      else                drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      settle();
      check("tie_release_cyc", 32'(s_cyc), 32'h0);
      tick();
      check("tie_idle_gap", 32'(s_cyc), 32'h0);
      tick();
      exp_addr = exp_q.pop_front();
      check("tie_second_cyc", 32'(s_cyc), 32'h1);
      check("tie_second_addr", s_addr, exp_addr);
      idle_masters();
      tick();
    end
    check("tie_queue_empty", 32'(exp_q.size()), 32'h0);

    // m1 write held against a mid-cycle m0 request
    drive_m1(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011);
    tick();
    check("wr_s_we", 32'(s_we), 32'h1);
    check("wr_s_sel", 32'(s_sel), 32'h3);
    check("wr_s_wdata", s_wdata, 32'h1234_5678);
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF);
    tick();
    s_ack = 1'b1;
    settle();
    check("wr_hold_addr", s_addr, 32'h0000_0040);
    check("wr_m1_ack", 32'(m1_ack), 32'h1);
    check("wr_m0_no_ack", 32'(m0_ack), 32'h0);
    tick();
    s_ack = 1'b0;
    m1_stb = 1'b0;
    settle();
    check("wr_hold_cyc", 32'(s_cyc), 32'h1);
    check("wr_hold_stb", 32'(s_stb), 32'h0);
    check("wr_hold_sel", 32'(s_sel), 32'h3);
    tick();
    drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    settle();
    check("wr_release_cyc", 32'(s_cyc), 32'h0);
    tick();
    check("wr_idle_gap", 32'(s_cyc), 32'h0);
    tick();
    check("wr_m0_granted", s_addr, 32'h0000_0080);
    idle_masters();
    tick();
    tick();

    // watchdog: eight stalled strobes, error on the ninth cycle only
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    tick();
    for (int k = 1; k <= TO; k++) begin
      check("to_no_err_yet", 32'(m0_err), 32'h0);
      tick();
    end
    check("to_m0_err", 32'(m0_err), 32'h1);
    check("to_m0_ack", 32'(m0_ack), 32'h0);
    check("to_m1_err", 32'(m1_err), 32'h0);
    tick();
    check("to_err_one_cycle", 32'(m0_err), 32'h0);
    check("to_grant_held", 32'(s_cyc), 32'h1);
    idle_masters();
    settle();
    check("to_release_cyc", 32'(s_cyc), 32'h0);
    tick();
    tick();

    // ack in the limit cycle wins over the timeout
    drive_m1(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    tick();
    for (int k = 1; k < TO; k++) tick();
    s_ack = 1'b1;
    settle();
    check("tie_ack_m1_ack", 32'(m1_ack), 32'h1);
    tick();
    s_ack = 1'b0;
    settle();
    check("tie_ack_no_err", 32'(m1_err), 32'h0);
    idle_masters();
    tick();
    tick();

    // asynchronous reset during GNT1, then the pending m0 request wins
    drive_m1(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    tick();
    drive_m0(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    settle();
    check("ar_pre_stb", 32'(s_stb), 32'h1);
    reset = 1'b1;
    settle();
    check("ar_async_cyc", 32'(s_cyc), 32'h0);
    check("ar_async_stb", 32'(s_stb), 32'h0);
    tick();
    drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b0;
    settle();
    check("ar_idle_cyc", 32'(s_cyc), 32'h0);
    tick();
    check("ar_m0_cyc", 32'(s_cyc), 32'h1);
    check("ar_m0_addr", s_addr, 32'h0000_0600);
    idle_masters();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
